// File: rtl/sa_drain_quant_pkg.sv
// ============================================================================
// sa_drain_quant_pkg : shared tile geometry, shift limit and drain FSM states
// Revision 1.0
// ============================================================================
`default_nettype none

package sa_drain_quant_pkg;

    localparam int SA_NCOL      = 4;
    localparam int SA_ACC_W     = 19;
    localparam int SA_OUT_W     = 8;
    localparam int SA_SHIFT_W   = 5;
    localparam int SA_SHIFT_MAX = 18;

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    function automatic logic [SA_SHIFT_W-1:0] clamp_shift(input logic [SA_SHIFT_W-1:0] s);
        return (s > SA_SHIFT_W'(SA_SHIFT_MAX)) ? SA_SHIFT_W'(SA_SHIFT_MAX) : s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sa_requant.sv
// ============================================================================
// sa_requant : round-half-up right shift of one accumulation, saturated to OUT_W
// Revision 1.0
// ============================================================================
`default_nettype none

module sa_requant
    import sa_drain_quant_pkg::*;
#(
    parameter int ACC_W = SA_ACC_W,
    parameter int OUT_W = SA_OUT_W
) (
    input  logic [ACC_W-1:0]      acc,
    input  logic [SA_SHIFT_W-1:0] shift,
    output logic [OUT_W-1:0]      q
);

    localparam int SUM_W = ACC_W + 1;
    localparam logic signed [SUM_W-1:0] MAX_Q = SUM_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] MIN_Q = SUM_W'(-(1 << (OUT_W - 1)));

    logic signed [SUM_W-1:0] ext;
    logic signed [SUM_W-1:0] rnd;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] shifted;

    // One extra bit keeps the rounding add from overflowing at full-scale input.
    always_comb begin
        ext     = {acc[ACC_W-1], acc};
        rnd     = (SUM_W'(1) << shift) >> 1;
        sum     = ext + rnd;
        shifted = sum >>> shift;
        if (shifted > MAX_Q) begin
            q = MAX_Q[OUT_W-1:0];
        end else if (shifted < MIN_Q) begin
            q = MIN_Q[OUT_W-1:0];
        end else begin
            q = shifted[OUT_W-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/sa_drain_quant.sv
// ============================================================================
// sa_drain_quant : collects a systolic tile, quantises it, drains it row by row
// Revision 1.0
// ============================================================================
`default_nettype none

module sa_drain_quant
    import sa_drain_quant_pkg::*;
#(
    parameter int NCOL  = SA_NCOL,
    parameter int ACC_W = SA_ACC_W,
    parameter int OUT_W = SA_OUT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    acc_valid,
    input  logic [NCOL*ACC_W-1:0]   acc_in,
    output logic                    acc_ready,
    input  logic [SA_SHIFT_W-1:0]   shift,
    output logic                    out_valid,
    output logic [NCOL*OUT_W-1:0]   out_data,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy
);

    localparam int ROW_W = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NCOL - 1);

    logic [0:0]               state;
    logic [ROW_W-1:0]         wr_row;
    logic [ROW_W-1:0]         rd_row;
    logic [SA_SHIFT_W-1:0]    shift_q;
    logic [NCOL*OUT_W-1:0]    tile [NCOL];

    logic                     beat;
    logic [SA_SHIFT_W-1:0]    eff_shift;
    logic [NCOL*OUT_W-1:0]    q_row;

    assign beat      = acc_valid && (state == ST_FILL);
    // Row 0 quantises with the live shift since the latched copy updates on that same edge.
    assign eff_shift = (wr_row == '0) ? clamp_shift(shift) : shift_q;

    generate
        for (genvar c = 0; c < NCOL; c++) begin : g_col
            sa_requant #(
                .ACC_W (ACC_W),
                .OUT_W (OUT_W)
            ) u_requant (
                .acc   (acc_in[c*ACC_W +: ACC_W]),
                .shift (eff_shift),
                .q     (q_row[c*OUT_W +: OUT_W])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_FILL;
            wr_row  <= '0;
            rd_row  <= '0;
            shift_q <= '0;
            for (int r = 0; r < NCOL; r++) begin
                tile[r] <= '0;
            end
        end else begin
            if (beat) begin
                tile[wr_row] <= q_row;
                if (wr_row == '0) begin
                    shift_q <= clamp_shift(shift);
                end
                if (wr_row == LAST_ROW) begin
                    wr_row <= '0;
                    state  <= ST_DRAIN;
                end else begin
                    wr_row <= wr_row + 1'b1;
                end
            end
            if ((state == ST_DRAIN) && out_ready) begin
                if (rd_row == LAST_ROW) begin
                    rd_row <= '0;
                    state  <= ST_FILL;
                end else begin
                    rd_row <= rd_row + 1'b1;
                end
            end
        end
    end

    assign acc_ready = (state == ST_FILL);
    assign busy      = (state == ST_DRAIN);
    assign out_valid = (state == ST_DRAIN);
    assign out_last  = out_valid && (rd_row == LAST_ROW);
    assign out_data  = out_valid ? tile[rd_row] : '0;

endmodule

`default_nettype wire

// File: tb/tb_sa_drain_quant.sv
// ============================================================================
// tb_sa_drain_quant : directed and random tiles checked against an integer model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_sa_drain_quant;

    localparam int NCOL  = 4;
    localparam int ACC_W = 19;
    localparam int OUT_W = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  acc_valid;
    logic [NCOL*ACC_W-1:0] acc_in;
    logic                  acc_ready;
    logic [4:0]            shift;
    logic                  out_valid;
    logic [NCOL*OUT_W-1:0] out_data;
    logic                  out_ready;
    logic                  out_last;
    logic                  busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sa_drain_quant dut (
        .clk       (clk),
        .reset     (reset),
        .acc_valid (acc_valid),
        .acc_in    (acc_in),
        .acc_ready (acc_ready),
        .shift     (shift),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference: round half up, floor-divide by 2^s, clamp to the int8 range.
    function automatic int quant(input int acc, input int sh);
        int s, p, v, q;
        s = (sh > 18) ? 18 : sh;
        p = 1 << s;
        v = acc + ((s > 0) ? p / 2 : 0);
        if (v >= 0) q = v / p;
        else        q = -((-v + p - 1) / p);
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    function automatic int rand_acc();
        logic signed [ACC_W-1:0] t;
        case ($urandom_range(0, 3))
            0: return int'($urandom_range(0, 600)) - 300;
            1: return ($urandom_range(0, 1) == 1) ? 262143 : -262144;
            default: begin
                t = ACC_W'($urandom);
                return int'(t);
            end
        endcase
    endfunction

    // mode 0: always ready; 1: random gaps/ready/junk pulses; 2: 3-cycle stall on row 1
    task automatic run_tile(input int vals[NCOL][NCOL], input int shifts[NCOL],
                            input int mode, input int rst_row, input string nm);
        logic [NCOL*OUT_W-1:0] exp_rows [NCOL];
        int row, cyc, stall;
        for (int r = 0; r < NCOL; r++)
            for (int c = 0; c < NCOL; c++)
                exp_rows[r][c*OUT_W +: OUT_W] = OUT_W'(quant(vals[r][c], shifts[0]));

        for (int r = 0; r < NCOL; r++) begin
            if (mode == 1) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    chk({nm, " idle_ready"}, 32'(acc_ready), 32'd1);
                    acc_valid = 1'b0;
                    acc_in    = {$urandom, $urandom, $urandom};
                    shift     = 5'($urandom);
                end
            end
            @(negedge clk);
            chk({nm, " fill_ready"}, 32'(acc_ready), 32'd1);
            chk({nm, " fill_ovalid"}, 32'(out_valid), 32'd0);
            acc_valid = 1'b1;
            for (int c = 0; c < NCOL; c++) acc_in[c*ACC_W +: ACC_W] = ACC_W'(vals[r][c]);
            shift = 5'(shifts[r]);
        end

        row = 0; cyc = 0; stall = 0;
        while (row < NCOL && cyc < 100) begin
            @(negedge clk);
            cyc++;
            chk({nm, " drain_valid"}, 32'(out_valid), 32'd1);
            chk({nm, " drain_data"}, out_data, exp_rows[row]);
            chk({nm, " drain_last"}, 32'(out_last), 32'(row == NCOL - 1));
            chk({nm, " drain_ready"}, 32'(acc_ready), 32'd0);
            chk({nm, " drain_busy"}, 32'(busy), 32'd1);
            if (row == rst_row) begin
                reset = 1'b1; out_ready = 1'b0; acc_valid = 1'b0;
                @(negedge clk);
                chk({nm, " rst_ovalid"}, 32'(out_valid), 32'd0);
                chk({nm, " rst_ready"}, 32'(acc_ready), 32'd1);
                chk({nm, " rst_busy"}, 32'(busy), 32'd0);
                chk({nm, " rst_data"}, out_data, 32'd0);
                reset = 1'b0;
                return;
            end
            acc_valid = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            acc_in    = {$urandom, $urandom, $urandom};
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (row == 1 && stall < 3) begin
                        out_ready = 1'b0; acc_valid = 1'b1; stall++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            if (out_ready) row++;
        end
        if (row < NCOL) chk({nm, " drain_timeout"}, 32'(row), 32'(NCOL));

        @(negedge clk);
        chk({nm, " post_ovalid"}, 32'(out_valid), 32'd0);
        chk({nm, " post_ready"}, 32'(acc_ready), 32'd1);
        chk({nm, " post_busy"}, 32'(busy), 32'd0);
        chk({nm, " post_last"}, 32'(out_last), 32'd0);
        chk({nm, " post_data"}, out_data, 32'd0);
        acc_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    int va [NCOL][NCOL];
    int sa [NCOL];

    initial begin
        reset = 1'b1; acc_valid = 1'b0; acc_in = '0; shift = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset acc_ready", 32'(acc_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", out_data, 32'd0);
        chk("reset out_last", 32'(out_last), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);

        // Saturating rows at shift 0: expect 7F7FFD05 on every row
        for (int r = 0; r < NCOL; r++) begin
            va[r][0] = 5; va[r][1] = -3; va[r][2] = 127; va[r][3] = 200;
            sa[r] = 0;
        end
        run_tile(va, sa, 0, -1, "sat_rows");

        // Shift 4 latched on beat 0, later beats drive shift 0
        va[0][0] = 24; va[0][1] = -24; va[0][2] = 7;   va[0][3] = 8;
        va[1][0] = 40; va[1][1] = -40; va[1][2] = 100; va[1][3] = -100;
        va[2][0] = 17; va[2][1] = -17; va[2][2] = 500; va[2][3] = -500;
        va[3][0] = 9;  va[3][1] = -9;  va[3][2] = 3000; va[3][3] = -3000;
        sa[0] = 4; sa[1] = 4; sa[2] = 0; sa[3] = 0;
        run_tile(va, sa, 0, -1, "shift_hold");

        for (int r = 0; r < NCOL; r++) begin
            va[r][0] = -262144; va[r][1] = 262143; va[r][2] = 0; va[r][3] = -1;
            sa[r] = 0;
        end
        run_tile(va, sa, 0, -1, "extremes");

        for (int r = 0; r < NCOL; r++) begin
            va[r][0] = 131072; va[r][1] = 131071; va[r][2] = -131072; va[r][3] = 262143;
            sa[r] = 31;
        end
        run_tile(va, sa, 0, -1, "clamp_shift");

        for (int r = 0; r < NCOL; r++) begin
            for (int c = 0; c < NCOL; c++) va[r][c] = rand_acc();
            sa[r] = 3;
        end
        run_tile(va, sa, 2, -1, "stall_row1");

        for (int r = 0; r < NCOL; r++) begin
            for (int c = 0; c < NCOL; c++) va[r][c] = rand_acc();
            sa[r] = 1;
        end
        run_tile(va, sa, 0, 2, "reset_drain");

        for (int r = 0; r < NCOL; r++) begin
            for (int c = 0; c < NCOL; c++) va[r][c] = rand_acc();
            sa[r] = 6;
        end
        run_tile(va, sa, 0, -1, "after_reset");

        for (int t = 0; t < 10; t++) begin
            for (int r = 0; r < NCOL; r++) begin
                for (int c = 0; c < NCOL; c++) va[r][c] = rand_acc();
                sa[r] = int'($urandom_range(0, 31));
            end
            run_tile(va, sa, 1, -1, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sa_drain_quant.md
SA_DRAIN_QUANT -- requirements
Module: sa_drain_quant

Interface
REQ-001 Parameter: NCOL, 4, number of systolic-array columns and rows per tile.
REQ-002 Parameter: ACC_W, 19, width of each signed column accumulation.
REQ-003 Parameter: OUT_W, 8, width of each signed quantised output element.
REQ-004 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: acc_valid  input  1  acc_in holds one valid row of NCOL accumulations.
REQ-007 Port: acc_in  input  NCOL*ACC_W (76)  column c at bits [c*ACC_W+ACC_W-1 : c*ACC_W], two's complement.
REQ-008 Port: acc_ready  output  1  block accepts acc_in this cycle.
REQ-009 Port: shift  input  5  requantisation right-shift amount.
REQ-010 Port: out_valid  output  1  out_data holds one valid quantised row.
REQ-011 Port: out_data  output  NCOL*OUT_W (32)  column c at bits [c*OUT_W+OUT_W-1 : c*OUT_W], two's complement.
REQ-012 Port: out_ready  input  1  downstream accepts out_data this cycle.
REQ-013 Port: out_last  output  1  qualifies the final row (row NCOL-1) of a tile.
REQ-014 Port: busy  output  1  high while in DRAIN state.

Function
REQ-015 State machine SHALL have two states: FILL (accept rows) and DRAIN (emit rows).
REQ-016 In FILL, acc_ready SHALL be 1; in DRAIN, acc_ready SHALL be 0 and acc_valid SHALL be ignored.
REQ-017 An input beat SHALL occur when acc_valid && acc_ready; beat k (0..NCOL-1) SHALL be written to tile row k.
REQ-018 shift SHALL be sampled on beat 0 of each tile and held for all rows of that tile; values >18 SHALL be clamped to 18.
REQ-019 Each element SHALL be quantised as: sign-extend to ACC_W+1 bits, add 2^(shift-1) when shift>0, arithmetic right shift by shift, saturate to [-128, 127].
REQ-020 Quantisation SHALL be applied on the write path; the tile buffer SHALL store NCOL x NCOL OUT_W-bit values.
REQ-021 The beat that completes row NCOL-1 SHALL move FILL->DRAIN; out_valid SHALL rise the following cycle with row 0 (latency 1 cycle).
REQ-022 In DRAIN, out_data SHALL present rows 0..NCOL-1 in order; row advances only on out_valid && out_ready.
REQ-023 While out_valid && !out_ready, out_data and out_last SHALL be held stable.
REQ-024 out_last SHALL be 1 exactly when out_valid and current row is NCOL-1.
REQ-025 The handshake on the out_last row SHALL move DRAIN->FILL with row counters cleared; acc_ready SHALL be 1 the next cycle.
REQ-026 out_valid SHALL be 0 in FILL; out_data SHALL be 0 when out_valid is 0.
REQ-027 Row counters SHALL wrap from NCOL-1 to 0 only via the state transitions above.

Reset
REQ-028 On reset: state=FILL, row counters=0, latched shift=0, tile buffer cleared to 0.
REQ-029 Reset values: acc_ready=1 (first cycle after reset release), out_valid=0, out_data=0, out_last=0, busy=0.
REQ-030 Reset asserted mid-FILL or mid-DRAIN SHALL discard the partial tile; no row SHALL be emitted afterwards from it.

Structure
REQ-031 NCOL, ACC_W, OUT_W, max shift (18) and the FILL/DRAIN state enum SHALL live in the shared MHA package.
REQ-032 Per-element rounding/saturation SHALL be one sub-module, sa_requant, instantiated NCOL times.
REQ-033 The block SHALL sit directly downstream of the 4x4 systolic array inside MHA, consuming its 76-bit column accumulation bus.

Verification
REQ-034 shift=0, rows all = {200,127,-3,5} (col3..col0), out_ready=1 -> 4 rows out_data=32'h7F7FFD05, out_last on 4th, first out_valid 1 cycle after 4th beat.
REQ-035 shift=4, row {8,7,-24,24} -> out_data=32'h0100FF02 (1,0,-1,2); shift changed to 0 on beat 2 -> rows 2,3 still use shift 4.
REQ-036 shift=0, col0=-262144, col1=262143 -> cols 0/1 = 8'h80/8'h7F; shift=31 -> clamped 18, acc 131072 -> 1.
REQ-037 out_ready held 0 for 3 cycles on row 1 -> out_data/out_last stable, acc_ready=0, acc_valid pulses ignored; then rows 1..3 emitted in order.
REQ-038 reset asserted on row 2 of DRAIN -> next cycle out_valid=0, acc_ready=1, busy=0; new tile drains correctly with no stale rows.
